wave_reader: RTL and testbench

Sample-side consumer of the waveform memory interface driven by the front-panel controller. It steps an 8-bit phase address on each `memclk` strobe and selects the waveform shape from `memmode`. It produces one 8-bit DAC code per step from a quarter-wave sine ROM or arithmetic shape generators. It sits between the controller and the DAC pins, in the same 50 MHz `clk` domain.

---
 rtl/wave_reader.sv | 91 +++++++++
 tb/tb_wave_reader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/wave_reader.sv
// wave_reader: steps an 8-bit phase on each memclk rising edge and emits one DAC code per step
// Ports: clk, rst (sync, active-high); memclk step strobe; memmode shape (00 sine, 01 square,
//   10 triangle, 11 sawtooth); dac_data/dac_valid registered sample; phase current address;
//   wrap pulses with dac_valid on the 255->0 step.
// Define WAVE_MEMCLK_SYNC_EN to pass memclk through a two-flop synchronizer (latency 4 instead of 2).
module wave_reader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memclk,
  input  logic [1:0]        memmode,
  output logic [DATA_W-1:0] dac_data,
  output logic              dac_valid,
  output logic [ADDR_W-1:0] phase,
  output logic              wrap
);
  localparam logic [6:0] SIN_Q [0:64] = '{
    7'd0,   7'd3,   7'd6,   7'd9,   7'd12,  7'd16,  7'd19,  7'd22,  7'd25,  7'd28,
    7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,  7'd49,  7'd51,  7'd54,  7'd57,
    7'd60,  7'd63,  7'd65,  7'd68,  7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,
    7'd85,  7'd88,  7'd90,  7'd92,  7'd94,  7'd96,  7'd98,  7'd100, 7'd102, 7'd104,
    7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116, 7'd117, 7'd118,
    7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124, 7'd125, 7'd125, 7'd126, 7'd126,
    7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };
  logic              memclk_s, step;
  logic              memclk_d_q, memclk_d_d;
  logic [ADDR_W-1:0] phase_q, phase_d;
  logic [1:0]        mode_q, mode_d;
  logic              pend_q, pend_d, pwrap_q, pwrap_d;
  logic [DATA_W-1:0] dac_data_q, dac_data_d;
  logic              dac_valid_q, dac_valid_d, wrap_q, wrap_d;
  logic [6:0]        rom_idx, sin_mag;
  logic [7:0]        sine_v, tri_v, shape_v;
`ifdef WAVE_MEMCLK_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge clk) begin
    if (rst) sync_q <= 2'b00;
    else     sync_q <= {sync_q[0], memclk};
  end
  assign memclk_s = sync_q[1];
`else
  assign memclk_s = memclk;
`endif
  always_comb begin
    step        = memclk_s & ~memclk_d_q;
    memclk_d_d  = memclk_s;
    phase_d     = step ? phase_q + 8'd1 : phase_q;
    mode_d      = (step && phase_q == 8'hff) ? memmode : mode_q;
    pend_d      = step;
    pwrap_d     = step && phase_q == 8'hff;
    // Quadrants 1 and 3 read the quarter-wave table mirrored
    rom_idx     = phase_q[6] ? 7'd64 - {1'b0, phase_q[5:0]} : {1'b0, phase_q[5:0]};
    sin_mag     = SIN_Q[rom_idx];
    sine_v      = phase_q[7] ? 8'd128 - {1'b0, sin_mag} : 8'd128 + {1'b0, sin_mag};
    tri_v       = phase_q[7] ? ~{phase_q[6:0], 1'b0} : {phase_q[6:0], 1'b0};
    shape_v     = mode_q == 2'd0 ? sine_v :
                  mode_q == 2'd1 ? (phase_q[7] ? 8'd0 : 8'd255) :
                  mode_q == 2'd2 ? tri_v : phase_q;
    dac_data_d  = pend_q ? shape_v : dac_data_q;
    dac_valid_d = pend_q;
    wrap_d      = pend_q & pwrap_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      memclk_d_q  <= 1'b1;
      phase_q     <= '0;
      mode_q      <= 2'd0;
      pend_q      <= 1'b0;
      pwrap_q     <= 1'b0;
      dac_data_q  <= 8'd128;
      dac_valid_q <= 1'b0;
      wrap_q      <= 1'b0;
    end else begin
      memclk_d_q  <= memclk_d_d;
      phase_q     <= phase_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      pwrap_q     <= pwrap_d;
      dac_data_q  <= dac_data_d;
      dac_valid_q <= dac_valid_d;
      wrap_q      <= wrap_d;
    end
  end
  assign dac_data  = dac_data_q;
  assign dac_valid = dac_valid_q;
  assign phase     = phase_q;
  assign wrap      = wrap_q;
endmodule

// File: tb/tb_wave_reader.sv
// tb_wave_reader: randomized and directed bench for wave_reader against a behavioural model
module tb_wave_reader;
  logic       clk, rst, memclk;
  logic [1:0] memmode;
  logic [7:0] dac_data, phase;
  logic       dac_valid, wrap;
  int checks = 0, failures = 0;
`ifdef WAVE_MEMCLK_SYNC_EN
  localparam int REL = 1;
`else
  localparam int REL = 0;
`endif
  wave_reader dut (
    .clk(clk), .rst(rst), .memclk(memclk), .memmode(memmode),
    .dac_data(dac_data), .dac_valid(dac_valid), .phase(phase), .wrap(wrap)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct {int due; int data; int wr;} exp_t;
  exp_t exp_q[$];
  int cyc = 0, m_phase = 0, m_mode = 0, last_data = 128, vcnt = 0, wcnt = 0;
  int obs [256];
  bit prev = 1'b1, eff, s1, s2;
  task automatic chk(string tag, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask
  function automatic int qv(int i);
    return $rtoi(127.0 * $sin(6.283185307179586 * i / 256.0) + 0.5);
  endfunction
  function automatic int shape(int mode, int a);
    int q, v;
    q = a % 64;
    v = qv(((a / 64) % 2) ? 64 - q : q);
    case (mode)
      0: return a >= 128 ? 128 - v : 128 + v;
      1: return a >= 128 ? 0 : 255;
      2: return a >= 128 ? 255 - 2 * (a - 128) : 2 * a;
      default: return a;
    endcase
  endfunction
  always begin
    exp_t e;
    bit ev;
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      m_phase = 0; m_mode = 0; prev = 1'b1; s1 = 1'b0; s2 = 1'b0; last_data = 128;
    end else begin
`ifdef WAVE_MEMCLK_SYNC_EN
      eff = s2; s2 = s1; s1 = memclk;
`else
      eff = memclk;
`endif
      if (eff && !prev) begin
        if (m_phase == 255) m_mode = memmode;
        m_phase = (m_phase + 1) % 256;
        e.due = cyc + 1; e.data = shape(m_mode, m_phase); e.wr = (m_phase == 0);
        exp_q.push_back(e);
      end
      prev = eff;
    end
    #1;
    ev = exp_q.size() > 0 && exp_q[0].due == cyc;
    chk("phase", phase, m_phase);
    chk("valid", dac_valid, ev);
    if (ev) begin
      e = exp_q.pop_front();
      chk("data", dac_data, e.data);
      chk("wrap", wrap, e.wr);
      last_data = e.data;
      obs[phase] = dac_data;
      vcnt++;
      if (wrap) wcnt++;
    end else begin
      chk("hold", dac_data, last_data);
      chk("wrap_idle", wrap, 0);
    end
  end
  task automatic cyc_wait(int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask
  task automatic pulse(int hi, int lo);
    memclk = 1'b1; cyc_wait(hi);
    memclk = 1'b0; cyc_wait(lo);
  endtask
  task automatic run_to(int target);
    int g = 0;
    while (m_phase != target && g < 600) begin pulse(1, 3); g++; end
    chk("run_to", m_phase, target);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    int p0, v0;
    rst = 1'b1; memclk = 1'b0; memmode = 2'd0;
    cyc_wait(3);
    chk("rst_data", dac_data, 128);
    chk("rst_phase", phase, 0);
    chk("rst_valid", dac_valid, 0);
    chk("rst_wrap", wrap, 0);
    rst = 1'b0;
    cyc_wait(2);
    repeat (256) pulse(1, 3);
    chk("sine_wraps", wcnt, 1);
    chk("sine_p1", obs[1], 131);
    chk("sine_p64", obs[64], 255);
    chk("sine_p128", obs[128], 128);
    chk("sine_p192", obs[192], 1);
    chk("sine_p0", obs[0], 128);
    run_to(100);
    memmode = 2'd3;
    run_to(0);
    run_to(5);
    chk("defer_p101_sine", obs[101], 206);
    chk("defer_p0_saw", obs[0], 0);
    chk("defer_p5_saw", obs[5], 5);
    memmode = 2'd2;
    run_to(255);
    pulse(1, 3);
    memmode = 2'd1;
    run_to(255);
    chk("tri_p127", obs[127], 254);
    chk("tri_p128", obs[128], 255);
    chk("tri_p255", obs[255], 1);
    pulse(1, 3);
    run_to(130);
    chk("sq_p127", obs[127], 255);
    chk("sq_p128", obs[128], 0);
    p0 = m_phase; v0 = vcnt;
    memclk = 1'b1; cyc_wait(20);
    memclk = 1'b0; cyc_wait(4);
    chk("held_phase", phase, (p0 + 1) % 256);
    chk("held_valid", vcnt - v0, 1);
    p0 = m_phase; v0 = vcnt;
    for (int i = 0; i < 20; i++) begin memclk = (i % 2 == 0); cyc_wait(1); end
    memclk = 1'b0; cyc_wait(4);
    chk("toggle_phase", phase, (p0 + 10) % 256);
    chk("toggle_valid", vcnt - v0, 10);
    repeat (400) begin
      memmode = 2'($urandom_range(0, 3));
      pulse($urandom_range(1, 3), $urandom_range(1, 3));
    end
    cyc_wait(4);
    memclk = 1'b1; cyc_wait(1);
    v0 = vcnt;
    rst = 1'b1; cyc_wait(2);
    chk("rstop_valid", vcnt - v0, 0);
    chk("rstop_phase", phase, 0);
    chk("rstop_data", dac_data, 128);
    rst = 1'b0; cyc_wait(6);
    chk("release_valid", vcnt - v0, REL);
    chk("release_phase", phase, REL);
    memclk = 1'b0; cyc_wait(3);
    memclk = 1'b1; cyc_wait(5);
    chk("rerise_phase", phase, REL + 1);
    memclk = 1'b0; cyc_wait(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
